// File: rtl/efuse_macro_emu.sv
// efuse_macro_emu: responder model of the 256-bit eFuse macro (one-time 0->1 fuses, byte reads).
// Define EFUSE_EMU_CHK_EN to add pulse-width/protocol checking and the sticky emu_err flags.
module efuse_macro_emu #(
    parameter int unsigned  TRD_MIN  = 2,
    parameter int unsigned  TPGM_MIN = 3,
    parameter logic [255:0] INIT_VAL = 256'h0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       efuse_pgmen_i,
    input  logic       efuse_rden_i,
    input  logic       efuse_aen_i,
    input  logic [7:0] efuse_addr_i,
    output logic [7:0] efuse_rdata_o,
    output logic [8:0] emu_pgm_cnt,
    output logic [2:0] emu_err,
    input  logic       emu_err_clr,
    output logic       emu_busy
);
    typedef enum logic [1:0] {StIdle, StRdAct, StPgmAct} state_e;

    state_e       r_state;
    logic         r_busy;
    logic [255:0] r_array;
    logic [7:0]   r_addr;
    logic         r_aen_prev;
    logic [7:0]   r_rdata;
    logic [8:0]   r_pgm_cnt;
    logic         w_rise;
    logic         w_rd_ok;
    logic         w_pgm_ok;

    assign w_rise        = efuse_aen_i & ~r_aen_prev;
    assign efuse_rdata_o = r_rdata;
    assign emu_pgm_cnt   = r_pgm_cnt;
    assign emu_busy      = r_busy;

`ifdef EFUSE_EMU_CHK_EN
    logic [9:0] r_cnt;
    logic [2:0] r_err;
    logic [2:0] w_err_set;
    logic       w_mode_pin;

    assign w_rd_ok  = (r_cnt >= 10'(TRD_MIN));
    assign w_pgm_ok = (r_cnt >= 10'(TPGM_MIN));
    assign emu_err  = r_err;

    always_comb begin
        w_mode_pin = (r_state == StRdAct) ? efuse_rden_i : efuse_pgmen_i;
        w_err_set  = 3'b000;
        if (r_state == StIdle && w_rise && efuse_pgmen_i && efuse_rden_i) begin
            w_err_set[2] = 1'b1;
        end
        if (r_state != StIdle && efuse_aen_i && (efuse_addr_i != r_addr || !w_mode_pin)) begin
            w_err_set[1] = 1'b1;
        end
        if (r_state == StRdAct && !efuse_aen_i && !w_rd_ok) begin
            w_err_set[0] = 1'b1;
        end
        if (r_state == StPgmAct && !efuse_aen_i && !w_pgm_ok) begin
            w_err_set[0] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
            r_err <= '0;
        end else begin
            // A coincident set survives the clear.
            r_err <= (emu_err_clr ? 3'b000 : r_err) | w_err_set;
            if (r_state == StIdle && w_rise) begin
                r_cnt <= 10'd1;
            end else if (r_state != StIdle && efuse_aen_i && r_cnt != 10'd1023) begin
                r_cnt <= r_cnt + 10'd1;
            end
        end
    end
`else
    logic w_unused;

    assign w_rd_ok  = 1'b1;
    assign w_pgm_ok = 1'b1;
    assign emu_err  = 3'b000;
    assign w_unused = ^{emu_err_clr, 10'(TRD_MIN), 10'(TPGM_MIN)};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= StIdle;
            r_busy     <= 1'b0;
            r_array    <= INIT_VAL;
            r_addr     <= '0;
            r_aen_prev <= 1'b0;
            r_rdata    <= '0;
            r_pgm_cnt  <= '0;
        end else begin
            r_aen_prev <= efuse_aen_i;
            unique case (r_state)
                StIdle: begin
                    // Conflicting or absent mode pins leave the pulse without effect.
                    if (w_rise && (efuse_rden_i ^ efuse_pgmen_i)) begin
                        r_addr  <= efuse_addr_i;
                        r_busy  <= 1'b1;
                        r_state <= efuse_rden_i ? StRdAct : StPgmAct;
                    end
                end
                StRdAct: begin
                    if (!efuse_aen_i) begin
                        r_rdata <= w_rd_ok ? r_array[{r_addr[7:3], 3'b000} +: 8] : 8'h00;
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end
                end
                StPgmAct: begin
                    if (!efuse_aen_i) begin
                        if (w_pgm_ok && !r_array[r_addr]) begin
                            r_array[r_addr] <= 1'b1;
                            if (r_pgm_cnt != 9'd256) begin
                                r_pgm_cnt <= r_pgm_cnt + 9'd1;
                            end
                        end
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_efuse_macro_emu.sv
// Self-checking bench for efuse_macro_emu: directed scenarios plus randomized pulses
// checked against a behavioural fuse-array model.
module tb_efuse_macro_emu;
    localparam int unsigned  TRD  = 2;
    localparam int unsigned  TPGM = 3;
    localparam logic [255:0] INIT = {192'h0, 64'hF0F1_F2F3_F4F5_F6F7};
`ifdef EFUSE_EMU_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       efuse_pgmen_i = 1'b0;
    logic       efuse_rden_i = 1'b0;
    logic       efuse_aen_i = 1'b0;
    logic [7:0] efuse_addr_i = 8'h00;
    logic [7:0] efuse_rdata_o;
    logic [8:0] emu_pgm_cnt;
    logic [2:0] emu_err;
    logic       emu_err_clr = 1'b0;
    logic       emu_busy;

    int n_vec = 0;
    int n_mis = 0;
    int busy_cycles;

    logic [255:0] m_arr;
    int           m_cnt;
    logic [2:0]   m_err;
    logic [7:0]   m_rdata;

    efuse_macro_emu #(
        .TRD_MIN (TRD),
        .TPGM_MIN(TPGM),
        .INIT_VAL(INIT)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .efuse_pgmen_i(efuse_pgmen_i),
        .efuse_rden_i (efuse_rden_i),
        .efuse_aen_i  (efuse_aen_i),
        .efuse_addr_i (efuse_addr_i),
        .efuse_rdata_o(efuse_rdata_o),
        .emu_pgm_cnt  (emu_pgm_cnt),
        .emu_err      (emu_err),
        .emu_err_clr  (emu_err_clr),
        .emu_busy     (emu_busy)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_arr   = INIT;
        m_cnt   = 0;
        m_err   = 3'b000;
        m_rdata = 8'h00;
    endtask

    // Drives one aen pulse of w high cycles, then applies the fuse rules to the model.
    task automatic pulse(input bit pg, input bit rd, input logic [7:0] a, input int w,
                         input logic [7:0] gmask, input bit clr);
        logic [2:0] set;
        int         b;
        busy_cycles   = 0;
        efuse_pgmen_i = pg;
        efuse_rden_i  = rd;
        efuse_addr_i  = a;
        efuse_aen_i   = 1'b1;
        for (int c = 0; c < w; c++) begin
            @(posedge clk);
            #1;
            if (emu_busy) busy_cycles++;
            if (c == 0) efuse_addr_i = a ^ gmask;
        end
        efuse_aen_i   = 1'b0;
        efuse_pgmen_i = 1'b0;
        efuse_rden_i  = 1'b0;
        emu_err_clr   = clr;
        @(posedge clk);
        #1;
        emu_err_clr = 1'b0;

        set = 3'b000;
        b   = int'(a[7:3]);
        if (pg && rd) begin
            set[2] = CHK;
        end else if (rd) begin
            if (gmask != 8'h00 && w >= 2) set[1] = CHK;
            if (!CHK || w >= TRD) begin
                m_rdata = m_arr[b*8 +: 8];
            end else begin
                m_rdata = 8'h00;
                set[0]  = 1'b1;
            end
        end else if (pg) begin
            if (gmask != 8'h00 && w >= 2) set[1] = CHK;
            if (!CHK || w >= TPGM) begin
                if (!m_arr[a]) begin
                    m_arr[a] = 1'b1;
                    if (m_cnt < 256) m_cnt++;
                end
            end else begin
                set[0] = 1'b1;
            end
        end
        if (CHK) m_err = clr ? set : (m_err | set);
    endtask

    task automatic clear_err();
        emu_err_clr = 1'b1;
        @(posedge clk);
        #1;
        emu_err_clr = 1'b0;
        m_err = 3'b000;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_vec++; if (efuse_rdata_o !== 8'h00) begin n_mis++; $display("FAIL rst_rdata: got %h expected 00", efuse_rdata_o); end
        n_vec++; if (emu_pgm_cnt !== 9'd0) begin n_mis++; $display("FAIL rst_cnt: got %0d expected 0", emu_pgm_cnt); end
        n_vec++; if (emu_err !== 3'b000) begin n_mis++; $display("FAIL rst_err: got %b expected 000", emu_err); end
        n_vec++; if (emu_busy !== 1'b0) begin n_mis++; $display("FAIL rst_busy: got %b expected 0", emu_busy); end
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_autoload();
        logic [63:0] img;
        for (int k = 0; k < 8; k++) begin
            pulse(1'b0, 1'b1, 8'(k * 8), 3, 8'h00, 1'b0);
            img[k*8 +: 8] = efuse_rdata_o;
        end
        n_vec++; if (img !== 64'hF0F1F2F3F4F5F6F7) begin n_mis++; $display("FAIL autoload_img: got %h expected F0F1F2F3F4F5F6F7", img); end
        n_vec++; if (emu_err !== 3'b000) begin n_mis++; $display("FAIL autoload_err: got %b expected 000", emu_err); end
    endtask

    task automatic test_read();
        pulse(1'b0, 1'b1, 8'h68, 3, 8'h00, 1'b0);
        n_vec++; if (efuse_rdata_o !== 8'h00) begin n_mis++; $display("FAIL read_rdata: got %h expected 00", efuse_rdata_o); end
        n_vec++; if (busy_cycles !== 3) begin n_mis++; $display("FAIL read_busy: got %0d cycles expected 3", busy_cycles); end
        n_vec++; if (emu_busy !== 1'b0) begin n_mis++; $display("FAIL read_idle: got %b expected 0", emu_busy); end
    endtask

    task automatic test_program();
        pulse(1'b1, 1'b0, 8'h6A, 3, 8'h00, 1'b0);
        pulse(1'b1, 1'b0, 8'h6F, 3, 8'h00, 1'b0);
        pulse(1'b0, 1'b1, 8'h68, 3, 8'h00, 1'b0);
        n_vec++; if (efuse_rdata_o !== 8'h84) begin n_mis++; $display("FAIL pgm_rdata: got %h expected 84", efuse_rdata_o); end
        n_vec++; if (emu_pgm_cnt !== 9'd2) begin n_mis++; $display("FAIL pgm_cnt: got %0d expected 2", emu_pgm_cnt); end
        pulse(1'b1, 1'b0, 8'h6A, 3, 8'h00, 1'b0);
        n_vec++; if (emu_pgm_cnt !== 9'd2) begin n_mis++; $display("FAIL reblow_cnt: got %0d expected 2", emu_pgm_cnt); end
        pulse(1'b0, 1'b1, 8'h68, 3, 8'h00, 1'b0);
        n_vec++; if (efuse_rdata_o !== 8'h84) begin n_mis++; $display("FAIL reblow_rdata: got %h expected 84", efuse_rdata_o); end
    endtask

    task automatic test_short_pgm();
        // Clear coincides with the timing violation: the new flag must survive.
        pulse(1'b1, 1'b0, 8'h80, 2, 8'h00, 1'b1);
        n_vec++; if (emu_err !== (CHK ? 3'b001 : 3'b000)) begin n_mis++; $display("FAIL short_err: got %b expected %b", emu_err, CHK ? 3'b001 : 3'b000); end
        pulse(1'b0, 1'b1, 8'h80, 3, 8'h00, 1'b0);
        n_vec++; if (efuse_rdata_o !== m_rdata) begin n_mis++; $display("FAIL short_rdata: got %h expected %h", efuse_rdata_o, m_rdata); end
        n_vec++; if (emu_pgm_cnt !== 9'(m_cnt)) begin n_mis++; $display("FAIL short_cnt: got %0d expected %0d", emu_pgm_cnt, m_cnt); end
        clear_err();
        n_vec++; if (emu_err !== 3'b000) begin n_mis++; $display("FAIL short_clr: got %b expected 000", emu_err); end
    endtask

    task automatic test_conflict();
        pulse(1'b1, 1'b1, 8'h90, 3, 8'h00, 1'b0);
        n_vec++; if (emu_err !== (CHK ? 3'b100 : 3'b000)) begin n_mis++; $display("FAIL conflict_err: got %b expected %b", emu_err, CHK ? 3'b100 : 3'b000); end
        n_vec++; if (busy_cycles !== 0) begin n_mis++; $display("FAIL conflict_busy: got %0d cycles expected 0", busy_cycles); end
        pulse(1'b0, 1'b1, 8'h90, 3, 8'h00, 1'b0);
        n_vec++; if (efuse_rdata_o !== 8'h00) begin n_mis++; $display("FAIL conflict_rdata: got %h expected 00", efuse_rdata_o); end
        clear_err();
    endtask

    task automatic test_glitch();
        pulse(1'b0, 1'b1, 8'h10, 3, 8'h01, 1'b0);
        n_vec++; if (emu_err !== (CHK ? 3'b010 : 3'b000)) begin n_mis++; $display("FAIL glitch_err: got %b expected %b", emu_err, CHK ? 3'b010 : 3'b000); end
        n_vec++; if (efuse_rdata_o !== 8'hF5) begin n_mis++; $display("FAIL glitch_rdata: got %h expected F5", efuse_rdata_o); end
        clear_err();
    endtask

    task automatic test_random();
        for (int i = 0; i < 80; i++) begin
            int         mode;
            int         w;
            bit         pg;
            bit         rd;
            logic [7:0] a;
            logic [7:0] gm;
            mode = int'($urandom_range(0, 9));
            rd   = (mode < 4) || (mode == 8);
            pg   = (mode >= 4 && mode < 8) || (mode == 8);
            a    = 8'($urandom_range(64, 127));
            w    = int'($urandom_range(1, 5));
            gm   = (w >= 2 && $urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            pulse(pg, rd, a, w, gm, $urandom_range(0, 5) == 0);
            n_vec++; if (efuse_rdata_o !== m_rdata) begin n_mis++; $display("FAIL rand_rdata[%0d]: got %h expected %h", i, efuse_rdata_o, m_rdata); end
            n_vec++; if (emu_pgm_cnt !== 9'(m_cnt)) begin n_mis++; $display("FAIL rand_cnt[%0d]: got %0d expected %0d", i, emu_pgm_cnt, m_cnt); end
            n_vec++; if (emu_err !== m_err) begin n_mis++; $display("FAIL rand_err[%0d]: got %b expected %b", i, emu_err, m_err); end
            n_vec++; if (emu_busy !== 1'b0) begin n_mis++; $display("FAIL rand_busy[%0d]: got %b expected 0", i, emu_busy); end
        end
    endtask

    task automatic test_rst_abort();
        efuse_pgmen_i = 1'b1;
        efuse_addr_i  = 8'hFF;
        efuse_aen_i   = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        n_vec++; if (emu_busy !== 1'b1) begin n_mis++; $display("FAIL abort_busy: got %b expected 1", emu_busy); end
        rst = 1'b1;
        #1;
        n_vec++; if (efuse_rdata_o !== 8'h00) begin n_mis++; $display("FAIL abort_rdata: got %h expected 00", efuse_rdata_o); end
        n_vec++; if (emu_pgm_cnt !== 9'd0) begin n_mis++; $display("FAIL abort_cnt: got %0d expected 0", emu_pgm_cnt); end
        n_vec++; if (emu_err !== 3'b000) begin n_mis++; $display("FAIL abort_err: got %b expected 000", emu_err); end
        n_vec++; if (emu_busy !== 1'b0) begin n_mis++; $display("FAIL abort_idle: got %b expected 0", emu_busy); end
        efuse_aen_i   = 1'b0;
        efuse_pgmen_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        pulse(1'b0, 1'b1, 8'hF8, 3, 8'h00, 1'b0);
        n_vec++; if (efuse_rdata_o[7] !== 1'b0) begin n_mis++; $display("FAIL abort_bit255: got %b expected 0", efuse_rdata_o[7]); end
        pulse(1'b0, 1'b1, 8'h68, 3, 8'h00, 1'b0);
        n_vec++; if (efuse_rdata_o !== 8'h00) begin n_mis++; $display("FAIL abort_array: got %h expected 00", efuse_rdata_o); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_autoload();
        test_read();
        test_program();
        test_short_pgm();
        test_conflict();
        test_glitch();
        test_random();
        test_rst_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule

// File: doc/efuse_macro_emu.md
Name: efuse_macro_emu

Overview:
- Synthesizable responder model of the 256-bit eFuse macro: the far end of the efuse_ctrl macro pins (pgmen/rden/aen/addr in, 8-bit rdata out).
- Used in FPGA prototypes and block-level sims in place of the hard macro.
- Holds a 256-bit fuse array with one-time 0->1 programming and returns 8-bit read data.
- Optionally checks pulse timing and protocol and reports sticky error flags.

Parameters:
- TRD_MIN, 2: minimum aen-high cycles for a valid read.
- TPGM_MIN, 3: minimum aen-high cycles for a valid program.
- INIT_VAL, 256'h0: array contents after reset (pre-blown die image).

Ports:
- clk  in  1  macro clock; same domain as efuse_ctrl.
- rst  in  1  asynchronous, active-high reset.
- efuse_pgmen_i  in  1  program-mode enable.
- efuse_rden_i  in  1  read-mode enable.
- efuse_aen_i  in  1  access strobe; high time = pulse width.
- efuse_addr_i  in  8  bit address; addr[7:3] is the byte index for reads.
- efuse_rdata_o  out  8  read byte.
- emu_pgm_cnt  out  9  count of bits newly blown since reset (0..256).
- emu_err  out  3  sticky flags: {mode_conflict, addr_glitch, timing_viol}.
- emu_err_clr  in  1  synchronous clear of emu_err.
- emu_busy  out  1  high while an access is in progress (state != IDLE).

Behaviour:
- Reset is asynchronous and active-high; clk is the only clock. All state is reset:
  - array <= INIT_VAL; efuse_rdata_o <= 0; emu_pgm_cnt <= 0; emu_err <= 0; state <= IDLE; pulse counter <= 0.
- All inputs are sampled on posedge clk.
- An aen rise is aen=1 while aen was 0 in the previous cycle (one-cycle registered history).
- FSM states: IDLE, RD_ACT, PGM_ACT.
- Transitions from IDLE on an aen rise:
  - rden=1, pgmen=0: go to RD_ACT. Latch byte index addr[7:3].
  - pgmen=1, rden=0: go to PGM_ACT. Latch bit address addr[7:0].
  - pgmen=rden=1: set mode_conflict, stay in IDLE, no array access.
  - pgmen=rden=0: ignore the pulse.
- In RD_ACT and PGM_ACT:
  - A 10-bit pulse counter starts at 1 on the rise and increments each cycle aen stays high, saturating at 1023.
  - addr or the active mode pin changing while aen is high sets addr_glitch. The latched address and mode are still used.
- aen fall in RD_ACT:
  - If count >= TRD_MIN: efuse_rdata_o[i] <= array[{byte,i}] for i=0..7, visible the cycle after the fall.
  - Otherwise: set timing_viol; efuse_rdata_o <= 8'h00.
  - Return to IDLE.
- aen fall in PGM_ACT:
  - If count >= TPGM_MIN: array[addr] <= 1.
  - emu_pgm_cnt increments only if that bit was 0. Re-blowing a 1 is legal and causes no change.
  - Otherwise: set timing_viol; the bit is unchanged. Return to IDLE.
- Array bits never return to 0 except through rst.
- efuse_rdata_o holds its last value between reads and while rden is low.
- The earliest re-entry from IDLE is a new rise on the next cycle (back-to-back pulses need one aen-low cycle).
- emu_err bits are sticky until emu_err_clr.
  - If a set and emu_err_clr coincide in the same cycle, the set wins.
- emu_pgm_cnt saturates at 256.
- rst during RD_ACT or PGM_ACT aborts the access: no array write, no rdata update.

Optional Feature:
- Macro: EFUSE_EMU_CHK_EN.
- Defined:
  - Pulse-width checks as above.
  - mode_conflict and addr_glitch detection.
  - Short pulses are rejected.
- Undefined:
  - Any completed aen pulse (count >= 1) reads or programs regardless of width.
  - emu_err tied to 3'b000.
  - mode_conflict is still resolved by taking no action.
  - The pulse counter is removed.

Test Plan:
- Reset with INIT_VAL=256'h0. Read byte 5 (addr=8'h28), aen high 3 cycles -> rdata=8'h00, emu_err=0, emu_busy high for 3 cycles.
- Program bits 8'h2A and 8'h2F, tpgm=3 each. Then read addr=8'h28 -> rdata=8'h84, emu_pgm_cnt=2.
- Program 8'h2A again -> emu_pgm_cnt stays 2, rdata on re-read stays 8'h84.
- Program 8'h00 with aen high 2 cycles (< TPGM_MIN) -> bit not set, emu_err=3'b001; emu_err_clr pulse -> 3'b000.
- pgmen=rden=1 with an aen pulse -> emu_err=3'b100, array unchanged.
- Change addr from 8'h10 to 8'h11 mid read pulse -> emu_err[1]=1, data returned from byte 2.
- Assert rst mid PGM_ACT on addr 8'hFF -> bit 255 stays 0 and all outputs return to reset values immediately.
- Drive efuse_ctrl autoload (trd=3) against this model with INIT_VAL[63:0]=64'hF0F1F2F3F4F5F6F7 -> controller rdata matches.
